// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if: one Sysbus request/response handshake channel.
// Ports (signals): reqcyc/req/reqtag/reqack request beat handshake,
//   respcyc/resp/resptag/respack response beat handshake.
// The master modport issues requests and consumes responses; the slave
// modport accepts requests and produces responses.
interface sysbus_arbiter_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          reqcyc;
  logic [DW-1:0] req;
  logic [TW-1:0] reqtag;
  logic          reqack;
  logic          respcyc;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;
  logic          respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin share of the Sysbus master port between the
// instruction-fetch (if_port) and data-memory (dm_port) stages; one burst at a time.
// Latency: one IDLE arbitration cycle before the address beat; beats pass through
//   combinationally. Backpressure: bus_reqack / owner respack stall the burst in place.
// Ports: clk, reset_n (async active-low); if_port, dm_port (slave side, from stages);
//   bus_port (master side, to the Sysbus pins).
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  sysbus_arbiter_if.slave   if_port,
  sysbus_arbiter_if.slave   dm_port,
  sysbus_arbiter_if.master  bus_port
);

  localparam int CW     = $clog2(BEATS) + 1;
  localparam int RD_BIT = 12;  // tag bit 12 set = read

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RRESP} state_e;

  state_e                   state_q, state_d;
  logic                     owner_q, owner_d;       // 0 = IF, 1 = DM
  logic                     last_owner_q, last_owner_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;           // address-beat tag, replayed on data beats

  // Owner-selected request side.
  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  assign own_reqcyc  = owner_q ? dm_port.reqcyc  : if_port.reqcyc;
  assign own_req     = owner_q ? dm_port.req     : if_port.req;
  assign own_reqtag  = owner_q ? dm_port.reqtag  : if_port.reqtag;
  assign own_respack = owner_q ? dm_port.respack : if_port.respack;

  logic req_beat, resp_beat;
  assign req_beat  = own_reqcyc & bus_port.reqack;
  assign resp_beat = bus_port.respcyc & own_respack;

  // Values returned to whichever port owns the bus; fanned out below.
  logic                      own_reqack_c, own_respcyc_c;
  logic [BUS_DATA_WIDTH-1:0] own_resp_c;
  logic [BUS_TAG_WIDTH-1:0]  own_resptag_c;
  logic                      bus_reqcyc_c, bus_respack_c;
  logic [BUS_DATA_WIDTH-1:0] bus_req_c;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // IF wins the first tie
      cnt_q        <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    own_reqack_c  = 1'b0;
    own_respcyc_c = 1'b0;
    own_resp_c    = '0;
    own_resptag_c = '0;
    bus_reqcyc_c  = 1'b0;
    bus_req_c     = '0;
    bus_reqtag_c  = '0;
    bus_respack_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_port.reqcyc || dm_port.reqcyc) begin
          state_d = ADDR;
          if (if_port.reqcyc && dm_port.reqcyc) owner_d = ~last_owner_q;
          else                                  owner_d = dm_port.reqcyc;
        end
      end
      ADDR: begin
        bus_reqcyc_c = own_reqcyc;
        bus_req_c    = own_req;
        bus_reqtag_c = own_reqtag;
        own_reqack_c = bus_port.reqack;
        if (req_beat) begin
          last_owner_d = owner_q;
          cnt_d        = '0;
          tag_d        = own_reqtag;
          state_d      = own_reqtag[RD_BIT] ? RRESP : WDATA;
        end
      end
      WDATA: begin
        bus_reqcyc_c = own_reqcyc;
        bus_req_c    = own_req;
        bus_reqtag_c = tag_q;
        own_reqack_c = bus_port.reqack;
        if (req_beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) state_d = IDLE;
        end
      end
      RRESP: begin
        own_respcyc_c = bus_port.respcyc;
        own_resp_c    = bus_port.resp;
        own_resptag_c = bus_port.resptag;
        bus_respack_c = own_respack;
        if (resp_beat) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_port.reqcyc  = bus_reqcyc_c;
  assign bus_port.req     = bus_req_c;
  assign bus_port.reqtag  = bus_reqtag_c;
  assign bus_port.respack = bus_respack_c;

  // Non-owner always sees an idle channel.
  assign if_port.reqack   = ~owner_q & own_reqack_c;
  assign if_port.respcyc  = ~owner_q & own_respcyc_c;
  assign if_port.resp     = owner_q ? '0 : own_resp_c;
  assign if_port.resptag  = owner_q ? '0 : own_resptag_c;
  assign dm_port.reqack   = owner_q & own_reqack_c;
  assign dm_port.respcyc  = owner_q & own_respcyc_c;
  assign dm_port.resp     = owner_q ? own_resp_c : '0;
  assign dm_port.resptag  = owner_q ? own_resptag_c : '0;

endmodule
